// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX pipeline stages and pipe_hazard_ctrl.
// The pipeline side uses the master modport, the hazard block uses the slave modport.
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        ex_load;
   logic [4:0]  ex_dst;
   logic        id_md_use;
   logic        ex_md_start;
   logic        ex_md_div;
   logic        pc_en;
   logic        fd_en;
   logic        de_clr;
   logic        stall;
   logic        md_busy;
   logic [15:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_load, ex_dst,
             id_md_use, ex_md_start, ex_md_div,
      input  pc_en, fd_en, de_clr, stall, md_busy, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_load, ex_dst,
             id_md_use, ex_md_start, ex_md_div,
      output pc_en, fd_en, de_clr, stall, md_busy, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use and mult/div busy stalls with bubble insert.
// Optional stall statistics counter is built only when STALL_STATS_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   pipe_hazard_ctrl_if.slave hz
);

   localparam logic [3:0] MULT_LD = MULT_CYCLES[3:0];
   localparam logic [3:0] DIV_LD  = DIV_CYCLES[3:0];

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   md_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       md_busy_s;
   logic       load_use_s;
   logic       md_stall_s;
   logic       stall_s;

   assign md_busy_s = (state_q == MD_BUSY);

   // Hazard detection; r0 is hard-wired zero so it never creates a dependency.
   always_comb begin
      load_use_s = 1'b0;
      md_stall_s = 1'b0;
      if (hz.ex_load && (hz.ex_dst != 5'd0)) begin
         load_use_s = (hz.id_use_rs && (hz.id_rs == hz.ex_dst)) ||
                      (hz.id_use_rt && (hz.id_rt == hz.ex_dst));
      end else begin
         load_use_s = 1'b0;
      end
      if (hz.id_md_use) begin
         md_stall_s = md_busy_s || hz.ex_md_start;
      end else begin
         md_stall_s = 1'b0;
      end
   end

   assign stall_s    = load_use_s || md_stall_s;
   assign hz.stall   = stall_s;
   assign hz.pc_en   = ~stall_s;
   assign hz.fd_en   = ~stall_s;
   assign hz.de_clr  = stall_s;
   assign hz.md_busy = md_busy_s;

   // Mult/div occupancy state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a start during BUSY is ignored; the last busy cycle has cnt_q == 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MD_IDLE: begin
            if (hz.ex_md_start) begin
               cnt_d   = hz.ex_md_div ? DIV_LD : MULT_LD;
               state_d = MD_BUSY;
            end else begin
               cnt_d   = cnt_q;
               state_d = MD_IDLE;
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = MD_IDLE;
            end else begin
               state_d = MD_BUSY;
            end
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = MD_IDLE;
         end
      endcase
   end

`ifdef STALL_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating stall counter increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall_cycles = stall_cnt_q;
`else
   assign hz.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table-driven hazard vectors plus
// multi-cycle mult/div, reset and stall-statistics sequences.
module tb_pipe_hazard_ctrl;

   logic clk;
   logic reset;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic       ld;
      logic [4:0] dst;
      logic       md_use;
      logic       md_start;
      logic       md_div;
      logic       rst;
      logic       exp_stall;
      logic       exp_busy;
   } vec_t;

   typedef struct {
      string      name;
      logic [4:0] outs;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic vec_t mk(input string n, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic ld,
                               input logic [4:0] dst, input logic mdu, input logic mds,
                               input logic mdd, input logic rst, input logic es,
                               input logic eb);
      vec_t v;
      v.name = n; v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
      v.ld = ld; v.dst = dst; v.md_use = mdu; v.md_start = mds; v.md_div = mdd;
      v.rst = rst; v.exp_stall = es; v.exp_busy = eb;
      return v;
   endfunction

   // Drive one cycle at the falling edge, push the expectation, compare mid-phase.
   task automatic cyc(input vec_t v);
      exp_t e;
      exp_t got;
      logic [4:0] act;
      @(negedge clk);
      hz.id_rs       = v.rs;
      hz.id_rt       = v.rt;
      hz.id_use_rs   = v.use_rs;
      hz.id_use_rt   = v.use_rt;
      hz.ex_load     = v.ld;
      hz.ex_dst      = v.dst;
      hz.id_md_use   = v.md_use;
      hz.ex_md_start = v.md_start;
      hz.ex_md_div   = v.md_div;
      reset          = v.rst;
      e.name = v.name;
      e.outs = {~v.exp_stall, ~v.exp_stall, v.exp_stall, v.exp_stall, v.exp_busy};
      q_exp.push_back(e);
      #2;
      got = q_exp.pop_front();
      act = {hz.pc_en, hz.fd_en, hz.de_clr, hz.stall, hz.md_busy};
      n_checks++;
      if (act !== got.outs) begin
         n_errors++;
         $display("FAIL %s: {pc_en,fd_en,de_clr,stall,md_busy} got %b expected %b",
                  got.name, act, got.outs);
      end
   endtask

   task automatic chk16(input string n, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   vec_t tbl[10];
   vec_t idle_v;
   vec_t lu_v;

   initial begin
      // Table of single-cycle hazard vectors with the mult/div unit idle.
      //            name          rs     rt     urs   urt   ld    dst    mdu   mds   mdd   rst   stl   bsy
      tbl[0] = mk("lu_rs",      5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[1] = mk("zero_reg",   5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[2] = mk("lu_rt",      5'd1,  5'd12, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[3] = mk("rt_unused",  5'd1,  5'd12, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[4] = mk("not_load",   5'd8,  5'd8,  1'b1, 1'b1, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[5] = mk("no_match",   5'd3,  5'd6,  1'b1, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[6] = mk("md_idle",    5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[7] = mk("rs_unused",  5'd5,  5'd5,  1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[8] = mk("lu_in_rst",  5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tbl[9] = mk("lu_r31",     5'd0,  5'd31, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle_v = mk("idle",       5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      lu_v   = mk("stat_lu",    5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      reset          = 1'b1;
      hz.id_rs       = 5'd0;
      hz.id_rt       = 5'd0;
      hz.id_use_rs   = 1'b0;
      hz.id_use_rt   = 1'b0;
      hz.ex_load     = 1'b0;
      hz.ex_dst      = 5'd0;
      hz.id_md_use   = 1'b0;
      hz.ex_md_start = 1'b0;
      hz.ex_md_div   = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      cyc(mk("reset_state", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      cyc(idle_v);
      chk16("reset_stall_cycles", hz.stall_cycles, 16'd0);

      for (int i = 0; i < 10; i++) cyc(tbl[i]);

      // Divide with id_md_use held: stall in start cycle and all 10 busy cycles.
      cyc(mk("div_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < 10; i++)
         cyc(mk($sformatf("div_busy%0d", i + 1), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      cyc(mk("div_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Multiply with a second start two cycles later that must be ignored.
      cyc(mk("mul_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      cyc(mk("mul_busy1", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      cyc(mk("mul_restart", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
      for (int i = 3; i <= 5; i++)
         cyc(mk($sformatf("mul_busy%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      cyc(mk("mul_done", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      cyc(mk("mul_idle", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Reset in busy cycle 3 of a divide abandons it.
      cyc(mk("rdiv_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      cyc(mk("rdiv_busy1", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      cyc(mk("rdiv_busy2", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      cyc(mk("rdiv_rst", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
      cyc(mk("rdiv_after", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk16("rdiv_stall_cycles", hz.stall_cycles, 16'd0);
      cyc(mk("rdiv_idle", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Seven load-use stalls after a reset.
      cyc(mk("stat_rst", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < 7; i++) cyc(lu_v);
      cyc(idle_v);
`ifdef STALL_STATS_EN
      chk16("stat_count7", hz.stall_cycles, 16'd7);
      @(negedge clk);
      force dut.stall_cnt_q = 16'hFFFF;
      cyc(lu_v);
      release dut.stall_cnt_q;
      cyc(lu_v);
      cyc(idle_v);
      chk16("stat_saturate", hz.stall_cycles, 16'hFFFF);
`else
      chk16("stat_disabled", hz.stall_cycles, 16'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
